// File: rtl/game_ctrl_1a2b.sv
// Bulls-and-cows ("1A2B") game controller: collects a four-digit guess from a
// keypad, scores it against a latched secret, and tracks attempts to WIN/LOSE.
module game_ctrl_1a2b #(
    parameter int unsigned MAX_TRIES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] rand_nums,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        back,
    input  logic        submit,
    output logic [15:0] guess,
    output logic [2:0]  digit_cnt,
    output logic [2:0]  a_cnt,
    output logic [2:0]  b_cnt,
    output logic        result_valid,
    output logic [3:0]  attempts,
    output logic        err,
    output logic [2:0]  state,
    output logic [15:0] secret_out
);

    localparam logic [3:0] MaxTries = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StInput = 3'd1,
        StCheck = 3'd2,
        StWin   = 3'd3,
        StLose  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] secret_q, secret_d;
    logic [15:0] guess_q, guess_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  a_q, a_d;
    logic [2:0]  b_q, b_d;
    logic        rv_q, rv_d;
    logic [3:0]  att_q, att_d;
    logic        err_q, err_d;

    logic [2:0]  score_a, score_b;
    logic        digit_dup;
    logic        digit_ok;
    logic        new_game;
    logic [3:0]  att_inc;

    // Same nibble index means same position; both words hold the first digit in [15:12].
    always_comb begin
        score_a = '0;
        score_b = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (guess_q[4*i +: 4] == secret_q[4*j +: 4]) begin
                    if (i == j) begin
                        score_a = score_a + 3'd1;
                    end else begin
                        score_b = score_b + 3'd1;
                    end
                end
            end
        end
    end

    // Only the low cnt_q nibbles hold keyed digits; the zero padding must not match digit 0.
    always_comb begin
        digit_dup = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) < cnt_q) && (guess_q[4*k +: 4] == digit)) begin
                digit_dup = 1'b1;
            end
        end
    end

    assign digit_ok = (digit <= 4'd9) && (cnt_q < 3'd4) && !digit_dup;
    assign att_inc  = att_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        secret_d = secret_q;
        guess_d  = guess_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        rv_d     = 1'b0;
        att_d    = att_q;
        err_d    = 1'b0;
        new_game = 1'b0;

        case (state_q)
            StIdle: begin
                new_game = start;
            end
            StInput: begin
                if (start) begin
                    new_game = 1'b1;
                end else if (back) begin
                    if (cnt_q != 3'd0) begin
                        guess_d = guess_q >> 4;
                        cnt_d   = cnt_q - 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (submit) begin
                    if (cnt_q == 3'd4) begin
                        state_d = StCheck;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (digit_valid) begin
                    if (digit_ok) begin
                        guess_d = {guess_q[11:0], digit};
                        cnt_d   = cnt_q + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StCheck: begin
                a_d   = score_a;
                b_d   = score_b;
                rv_d  = 1'b1;
                att_d = att_inc;
                if (score_a == 3'd4) begin
                    state_d = StWin;
                end else if (att_inc == MaxTries) begin
                    state_d = StLose;
                end else begin
                    state_d = StInput;
                    guess_d = '0;
                    cnt_d   = '0;
                end
            end
            StWin, StLose: begin
                new_game = start;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (new_game) begin
            state_d  = StInput;
            secret_d = rand_nums;
            guess_d  = '0;
            cnt_d    = '0;
            a_d      = '0;
            b_d      = '0;
            att_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            secret_q <= '0;
            guess_q  <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rv_q     <= 1'b0;
            att_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            secret_q <= secret_d;
            guess_q  <= guess_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rv_q     <= rv_d;
            att_q    <= att_d;
            err_q    <= err_d;
        end
    end

    assign guess        = guess_q;
    assign digit_cnt    = cnt_q;
    assign a_cnt        = a_q;
    assign b_cnt        = b_q;
    assign result_valid = rv_q;
    assign attempts     = att_q;
    assign err          = err_q;
    assign state        = state_q;
    assign secret_out   = ((state_q == StWin) || (state_q == StLose)) ? secret_q : '0;

endmodule

// File: tb/tb_game_ctrl_1a2b.sv
// Bench for game_ctrl_1a2b: directed game scenarios with literal expectations plus
// randomized play checked every cycle against a queue-based game model.
module tb_game_ctrl_1a2b;

    localparam int MAXT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] rand_nums = '0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = '0;
    logic        back = 1'b0;
    logic        submit = 1'b0;
    logic [15:0] guess;
    logic [2:0]  digit_cnt;
    logic [2:0]  a_cnt;
    logic [2:0]  b_cnt;
    logic        result_valid;
    logic [3:0]  attempts;
    logic        err;
    logic [2:0]  state;
    logic [15:0] secret_out;

    game_ctrl_1a2b #(.MAX_TRIES(MAXT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rand_nums    (rand_nums),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .back         (back),
        .submit       (submit),
        .guess        (guess),
        .digit_cnt    (digit_cnt),
        .a_cnt        (a_cnt),
        .b_cnt        (b_cnt),
        .result_valid (result_valid),
        .attempts     (attempts),
        .err          (err),
        .state        (state),
        .secret_out   (secret_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Game model: state numbers follow the output encoding, guess kept as a digit queue.
    int m_st;
    int m_sec[4];
    int m_keys[$];
    int m_a, m_b, m_att;
    bit m_rv, m_err;

    task automatic model_reset();
        m_st = 0;
        for (int i = 0; i < 4; i++) m_sec[i] = 0;
        m_keys.delete();
        m_a = 0; m_b = 0; m_att = 0; m_rv = 0; m_err = 0;
    endtask

    task automatic model_new();
        for (int i = 0; i < 4; i++) m_sec[i] = int'(rand_nums[4*(3-i) +: 4]);
        m_keys.delete();
        m_a = 0; m_b = 0; m_att = 0;
        m_st = 1;
    endtask

    function automatic bit keyed(input int d);
        foreach (m_keys[k]) if (m_keys[k] == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int a, b;
        m_rv = 0;
        m_err = 0;
        case (m_st)
            1: begin
                if (start) model_new();
                else if (back) begin
                    if (m_keys.size() > 0) void'(m_keys.pop_back());
                    else m_err = 1;
                end else if (submit) begin
                    if (m_keys.size() == 4) m_st = 2;
                    else m_err = 1;
                end else if (digit_valid) begin
                    if (int'(digit) <= 9 && m_keys.size() < 4 && !keyed(int'(digit)))
                        m_keys.push_back(int'(digit));
                    else m_err = 1;
                end
            end
            2: begin
                a = 0;
                b = 0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        if (m_keys[i] == m_sec[j]) begin
                            if (i == j) a++;
                            else b++;
                        end
                m_a = a; m_b = b; m_rv = 1; m_att++;
                if (a == 4) m_st = 3;
                else if (m_att == MAXT) m_st = 4;
                else begin
                    m_st = 1;
                    m_keys.delete();
                end
            end
            default: if (start) model_new();
        endcase
    endtask

    function automatic logic [15:0] pack_keys();
        logic [15:0] g;
        g = '0;
        foreach (m_keys[k]) g = {g[11:0], 4'(m_keys[k])};
        return g;
    endfunction

    function automatic logic [15:0] pack_sec();
        return {4'(m_sec[0]), 4'(m_sec[1]), 4'(m_sec[2]), 4'(m_sec[3])};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("state", 32'(state), 32'(m_st));
            chk("guess", 32'(guess), 32'(pack_keys()));
            chk("digit_cnt", 32'(digit_cnt), 32'(m_keys.size()));
            chk("a_cnt", 32'(a_cnt), 32'(m_a));
            chk("b_cnt", 32'(b_cnt), 32'(m_b));
            chk("result_valid", 32'(result_valid), 32'(m_rv));
            chk("attempts", 32'(attempts), 32'(m_att));
            chk("err", 32'(err), 32'(m_err));
            chk("secret_out", 32'(secret_out),
                (m_st == 3 || m_st == 4) ? 32'(pack_sec()) : 32'd0);
            chk("err_rv_excl", 32'(err & result_valid), 32'd0);
            chk("att_bound", 32'(32'(attempts) <= MAXT), 32'd1);
        end
    end

    // Inputs are applied from one negedge to the next, so each command hits exactly one edge.
    task automatic drive(input bit s, input bit bk, input bit sb, input bit dv,
                         input logic [3:0] d, input logic [15:0] rn);
        start = s; back = bk; submit = sb; digit_valid = dv; digit = d; rand_nums = rn;
        @(negedge clk);
        start = 0; back = 0; submit = 0; digit_valid = 0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 4'h0, rand_nums);
    endtask

    task automatic key(input logic [3:0] d);
        drive(0, 0, 0, 1, d, rand_nums);
    endtask

    task automatic new_game(input logic [15:0] rn);
        drive(1, 0, 0, 0, 4'h0, rn);
    endtask

    task automatic key4(input logic [15:0] g);
        for (int i = 3; i >= 0; i--) key(g[4*i +: 4]);
    endtask

    function automatic logic [15:0] rand_secret();
        int d[10];
        int j, t;
        for (int i = 0; i < 10; i++) d[i] = i;
        for (int i = 9; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = d[i]; d[i] = d[j]; d[j] = t;
        end
        return {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
    endfunction

    initial begin
        logic [3:0] dsel;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_secret", 32'(secret_out), 32'd0);
        rst_n = 1'b1;
        idle();
        drive(0, 1, 1, 1, 4'h3, 16'h0);
        chk("idle_ignore_state", 32'(state), 32'd0);
        chk("idle_ignore_err", 32'(err), 32'd0);

        // 1736 vs 1376: two in place, two swapped.
        new_game(16'h1736);
        chk("start_state", 32'(state), 32'd1);
        key4(16'h1376);
        drive(0, 0, 1, 0, 4'h0, 16'h0);
        chk("check_state", 32'(state), 32'd2);
        idle();
        chk("r35_a", 32'(a_cnt), 32'd2);
        chk("r35_b", 32'(b_cnt), 32'd2);
        chk("r35_rv", 32'(result_valid), 32'd1);
        chk("r35_att", 32'(attempts), 32'd1);
        chk("r35_state", 32'(state), 32'd1);
        chk("r35_cnt", 32'(digit_cnt), 32'd0);
        idle();
        chk("r35_rv_pulse", 32'(result_valid), 32'd0);

        key4(16'h1736);
        drive(0, 0, 1, 0, 4'h0, 16'h0);
        idle();
        chk("r36_a", 32'(a_cnt), 32'd4);
        chk("r36_b", 32'(b_cnt), 32'd0);
        chk("r36_state", 32'(state), 32'd3);
        chk("r36_secret", 32'(secret_out), 32'h1736);
        key(4'h5);
        chk("r36_hold_guess", 32'(guess), 32'h1736);
        chk("r36_hold_err", 32'(err), 32'd0);

        new_game(16'h1736);
        key(4'h2);
        key(4'h2);
        chk("r37_dup_err", 32'(err), 32'd1);
        key(4'hA);
        chk("r37_big_err", 32'(err), 32'd1);
        chk("r37_guess", 32'(guess), 32'h0002);
        chk("r37_cnt", 32'(digit_cnt), 32'd1);
        drive(0, 1, 0, 0, 4'h0, 16'h0);
        chk("r37_back", 32'(digit_cnt), 32'd0);
        chk("r37_back_noerr", 32'(err), 32'd0);
        drive(0, 1, 0, 0, 4'h0, 16'h0);
        chk("r37_back_err", 32'(err), 32'd1);

        key4(16'h0245);
        drive(0, 1, 1, 1, 4'h8, 16'h0);
        chk("r39_cnt", 32'(digit_cnt), 32'd3);
        chk("r39_state", 32'(state), 32'd1);
        chk("r39_err", 32'(err), 32'd0);
        chk("r39_guess", 32'(guess), 32'h0024);

        new_game(16'h1736);
        for (int n = 1; n <= MAXT; n++) begin
            key4(16'h0245);
            drive(0, 0, 1, 0, 4'h0, 16'h0);
            idle();
            chk("r38_a", 32'(a_cnt), 32'd0);
            chk("r38_b", 32'(b_cnt), 32'd0);
            chk("r38_att", 32'(attempts), 32'(n));
        end
        chk("r38_state", 32'(state), 32'd4);
        chk("r38_secret", 32'(secret_out), 32'h1736);
        new_game(16'h4321);
        chk("lose_restart_state", 32'(state), 32'd1);
        chk("lose_restart_att", 32'(attempts), 32'd0);

        key(4'h9); key(4'h8); key(4'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("r40_state", 32'(state), 32'd0);
        chk("r40_guess", 32'(guess), 32'd0);
        chk("r40_cnt", 32'(digit_cnt), 32'd0);
        chk("r40_att", 32'(attempts), 32'd0);
        chk("r40_secret", 32'(secret_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 1, 0, 4'h0, 16'h0);
        chk("r40_submit_state", 32'(state), 32'd0);
        chk("r40_submit_err", 32'(err), 32'd0);

        // Random play; half the keyed digits follow the secret so wins occur.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 1 && m_keys.size() < 4) dsel = 4'(m_sec[m_keys.size()]);
            else dsel = 4'($urandom_range(0, 11));
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, dsel, rand_secret());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
